// File: rtl/bp_eth_pkg.sv
// Shared Ethernet-engine types: BlackParrot config widths, BedRock memory message
// layout, Ethernet command codes and TX state / software status encodings.
package bp_eth_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  localparam int unsigned bp_default_paddr_width     = 40;
  localparam int unsigned bp_default_cce_block_width = 512;
  localparam int unsigned bp_default_lce_id_width    = 4;

  function automatic int unsigned bp_paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_default_paddr_width;
      default:          return bp_default_paddr_width;
    endcase
  endfunction

  function automatic int unsigned bp_cce_block_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_default_cce_block_width;
      default:          return bp_default_cce_block_width;
    endcase
  endfunction

  function automatic int unsigned bp_lce_id_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_default_lce_id_width;
      default:          return bp_default_lce_id_width;
    endcase
  endfunction

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic [3:0] {
    e_bedrock_load  = 4'd0,
    e_bedrock_store = 4'd1
  } bp_bedrock_subop_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [2:0]                         state;
    logic [2:0]                         way_id;
    logic [bp_default_lce_id_width-1:0] lce_id;
    logic                               prefetch;
    logic                               uncached;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s           payload;
    bp_bedrock_msg_size_e              size;
    logic [bp_default_paddr_width-1:0] addr;
    bp_bedrock_subop_e                 subop;
    bp_bedrock_mem_type_e              msg_type;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    logic [bp_default_cce_block_width-1:0] data;
    bp_bedrock_mem_header_s                header;
  } bp_bedrock_mem_msg_s;

  typedef enum logic [2:0] {
    ETH_CMD_RX_SET_BUF_ADDR = 3'b001,
    ETH_CMD_RX_RECV         = 3'b010,
    ETH_CMD_TX_SET_BUF_ADDR = 3'b011,
    ETH_CMD_TX_SEND         = 3'b100
  } eth_cmd_e;

  typedef enum logic [2:0] {
    E_TX_INIT      = 3'd0,
    E_TX_IDLE      = 3'd1,
    E_TX_READ      = 3'd2,
    E_TX_WAIT_RESP = 3'd3,
    E_TX_STREAM    = 3'd4
  } eth_tx_state_e;

  typedef enum logic [1:0] {
    E_EXT_INIT = 2'b00,
    E_EXT_BUSY = 2'b01,
    E_EXT_IDLE = 2'b10
  } eth_ext_state_e;

endpackage

// File: rtl/to_tx_axis.sv
// Ethernet TX DMA: reads a software buffer one 64-bit word at a time over the
// BedRock uncached interface and streams each word out as one AXIS beat.
module to_tx_axis
  import bp_eth_pkg::*;
  #(parameter  bp_params_e  bp_params_p          = e_bp_default_cfg
   ,localparam int unsigned paddr_width_p        = bp_paddr_width(bp_params_p)
   ,localparam int unsigned cce_block_width_p    = bp_cce_block_width(bp_params_p)
   ,localparam int unsigned lce_id_width_p       = bp_lce_id_width(bp_params_p)
   ,parameter  int unsigned axis_data_width_p    = 64
   ,parameter  int unsigned reg_addr_width_p     = paddr_width_p
   ,parameter  int unsigned eth_tx_state_width_p = 3
   ,parameter  int unsigned eth_cmd_width_p      = 3
   ,localparam int unsigned cce_mem_msg_width_lp = $bits(bp_bedrock_mem_header_s) + cce_block_width_p
   )
  (input  logic                            clk_i
  ,input  logic                            reset_n_i
  ,input  logic [lce_id_width_p-1:0]       lce_id_i
  ,input  logic [eth_cmd_width_p-1:0]      eth_cmd_i
  ,input  logic                            eth_cmd_v_i
  ,input  logic [reg_addr_width_p-1:0]     eth_cmd_arg_i
  ,output logic [cce_mem_msg_width_lp-1:0] io_cmd_o
  ,output logic                            io_cmd_v_o
  ,input  logic                            io_cmd_yumi_i
  ,input  logic [cce_mem_msg_width_lp-1:0] io_resp_i
  ,input  logic                            io_resp_v_i
  ,output logic                            io_resp_ready_o
  ,output logic [axis_data_width_p-1:0]    tx_axis_tdata_o
  ,output logic [7:0]                      tx_axis_tkeep_o
  ,output logic                            tx_axis_tvalid_o
  ,input  logic                            tx_axis_tready_i
  ,output logic                            tx_axis_tlast_o
  ,output logic                            tx_axis_tuser_o
  ,output logic [1:0]                      tx_ext_state_o
  );

  if (axis_data_width_p != 64) begin : g_bad_axis_width
    $error("to_tx_axis supports only a 64-bit AXIS beat");
  end
  if (eth_tx_state_width_p < $bits(eth_tx_state_e)) begin : g_bad_state_width
    $error("to_tx_axis state width too small for the TX state set");
  end
  if (eth_cmd_width_p != $bits(eth_cmd_e)) begin : g_bad_cmd_width
    $error("to_tx_axis command width must match eth_cmd_e");
  end
  if (reg_addr_width_p < 16) begin : g_bad_addr_width
    $error("to_tx_axis buffer address must hold the 16-bit length field");
  end

  eth_tx_state_e state_r, state_n;

  logic [reg_addr_width_p-1:0]  buf_addr_r;
  logic [15:0]                  remaining_r;
  logic [15:0]                  offset_r;
  logic [axis_data_width_p-1:0] beat_r;

  logic        cmd_set, cmd_send;
  logic [15:0] send_len;
  logic        stream_last;
  logic [7:0]  keep_partial;
  logic        buf_en, frame_start, beat_en, beat_advance;

  assign cmd_set     = eth_cmd_v_i && (eth_cmd_i == eth_cmd_width_p'(ETH_CMD_TX_SET_BUF_ADDR));
  assign cmd_send    = eth_cmd_v_i && (eth_cmd_i == eth_cmd_width_p'(ETH_CMD_TX_SEND));
  assign send_len    = eth_cmd_arg_i[15:0];
  assign stream_last = (remaining_r <= 16'd8);
  // Low 'remaining' bytes valid on a short tail beat.
  assign keep_partial = 8'((9'd1 << remaining_r[2:0]) - 9'd1);

  bp_bedrock_mem_msg_s         cmd_msg, resp_msg;
  logic [reg_addr_width_p-1:0] rd_addr;
  logic                        unused_resp_bits;

  assign rd_addr  = buf_addr_r + reg_addr_width_p'(offset_r);
  assign resp_msg = io_resp_i;
  assign unused_resp_bits = ^{resp_msg.header, resp_msg.data[cce_block_width_p-1:axis_data_width_p]};

  always_comb begin
    cmd_msg                        = '0;
    cmd_msg.header.msg_type        = e_bedrock_mem_uc_rd;
    cmd_msg.header.subop           = e_bedrock_load;
    cmd_msg.header.size            = e_bedrock_msg_size_8;
    cmd_msg.header.addr            = paddr_width_p'(rd_addr);
    cmd_msg.header.payload.lce_id  = lce_id_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= E_TX_INIT;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      E_TX_INIT:      if (cmd_set) state_n = E_TX_IDLE;
      E_TX_IDLE:      if (cmd_send && (send_len != 16'd0)) state_n = E_TX_READ;
      E_TX_READ:      if (io_cmd_yumi_i) state_n = E_TX_WAIT_RESP;
      E_TX_WAIT_RESP: if (io_resp_v_i) state_n = E_TX_STREAM;
      E_TX_STREAM:    if (tx_axis_tready_i) state_n = stream_last ? E_TX_IDLE : E_TX_READ;
      default:        state_n = E_TX_INIT;
    endcase
  end

  assign buf_en       = cmd_set && ((state_r == E_TX_INIT) || (state_r == E_TX_IDLE));
  assign frame_start  = cmd_send && (send_len != 16'd0) && (state_r == E_TX_IDLE);
  assign beat_en      = io_resp_v_i && (state_r == E_TX_WAIT_RESP);
  assign beat_advance = tx_axis_tready_i && !stream_last && (state_r == E_TX_STREAM);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      buf_addr_r  <= '0;
      remaining_r <= '0;
      offset_r    <= '0;
    end else begin
      if (buf_en) buf_addr_r <= eth_cmd_arg_i;
      if (frame_start) begin
        remaining_r <= send_len;
        offset_r    <= '0;
      end else if (beat_advance) begin
        remaining_r <= remaining_r - 16'd8;
        offset_r    <= offset_r + 16'd8;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   beat_r <= '0;
    else if (beat_en) beat_r <= resp_msg.data[axis_data_width_p-1:0];
  end

  always_comb begin
    io_cmd_o         = '0;
    io_cmd_v_o       = 1'b0;
    io_resp_ready_o  = 1'b0;
    tx_axis_tdata_o  = '0;
    tx_axis_tkeep_o  = '0;
    tx_axis_tvalid_o = 1'b0;
    tx_axis_tlast_o  = 1'b0;
    tx_ext_state_o   = E_EXT_INIT;
    case (state_r)
      E_TX_INIT: tx_ext_state_o = E_EXT_INIT;
      E_TX_IDLE: tx_ext_state_o = E_EXT_IDLE;
      E_TX_READ: begin
        io_cmd_o       = cmd_msg;
        io_cmd_v_o     = 1'b1;
        tx_ext_state_o = E_EXT_BUSY;
      end
      E_TX_WAIT_RESP: begin
        io_resp_ready_o = 1'b1;
        tx_ext_state_o  = E_EXT_BUSY;
      end
      E_TX_STREAM: begin
        tx_axis_tvalid_o = 1'b1;
        tx_axis_tdata_o  = beat_r;
        tx_axis_tkeep_o  = (remaining_r >= 16'd8) ? 8'hFF : keep_partial;
        tx_axis_tlast_o  = stream_last;
        tx_ext_state_o   = E_EXT_BUSY;
      end
      default: tx_ext_state_o = E_EXT_INIT;
    endcase
  end

  assign tx_axis_tuser_o = 1'b0;

endmodule

// File: tb/tb_to_tx_axis.sv
// Scoreboard bench for to_tx_axis: a frame-level model predicts reads and beats,
// a responder plays memory, and a monitor checks everything the DUT presents.
module tb_to_tx_axis;
  import bp_eth_pkg::*;

  localparam int unsigned MSGW = $bits(bp_bedrock_mem_msg_s);
  localparam int unsigned AW   = bp_default_paddr_width;
  localparam int unsigned LW   = bp_default_lce_id_width;

  logic            clk = 1'b0;
  logic            reset_n_i = 1'b0;
  logic [LW-1:0]   lce_id_i = '0;
  logic [2:0]      eth_cmd_i = '0;
  logic            eth_cmd_v_i = 1'b0;
  logic [AW-1:0]   eth_cmd_arg_i = '0;
  logic [MSGW-1:0] io_cmd_o;
  logic            io_cmd_v_o;
  logic            io_cmd_yumi_i = 1'b0;
  logic [MSGW-1:0] io_resp_i = '0;
  logic            io_resp_v_i = 1'b0;
  logic            io_resp_ready_o;
  logic [63:0]     tx_axis_tdata_o;
  logic [7:0]      tx_axis_tkeep_o;
  logic            tx_axis_tvalid_o;
  logic            tx_axis_tready_i = 1'b0;
  logic            tx_axis_tlast_o;
  logic            tx_axis_tuser_o;
  logic [1:0]      tx_ext_state_o;

  always #5 clk = ~clk;

  to_tx_axis #(.bp_params_p(e_bp_default_cfg), .axis_data_width_p(64)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i),
    .eth_cmd_i(eth_cmd_i), .eth_cmd_v_i(eth_cmd_v_i), .eth_cmd_arg_i(eth_cmd_arg_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o),
    .tx_axis_tdata_o(tx_axis_tdata_o), .tx_axis_tkeep_o(tx_axis_tkeep_o),
    .tx_axis_tvalid_o(tx_axis_tvalid_o), .tx_axis_tready_i(tx_axis_tready_i),
    .tx_axis_tlast_o(tx_axis_tlast_o), .tx_axis_tuser_o(tx_axis_tuser_o),
    .tx_ext_state_o(tx_ext_state_o));

  typedef struct packed { logic [7:0] keep; logic last; } beat_exp_s;

  bp_bedrock_mem_msg_s exp_cmd_q[$];
  beat_exp_s           exp_beat_q[$];
  logic [63:0]         data_q[$];

  int unsigned total = 0, bad = 0;
  int unsigned pending = 0;
  bit          cfg = 1'b0;
  logic [AW-1:0] m_buf = '0;
  int unsigned stall_left = 0;
  bit          force_yumi_delay = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_msg(input string nm, input logic [MSGW-1:0] act, input logic [MSGW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame model: one 8-byte read per beat, keep counts the bytes left in the frame.
  task automatic expect_frame(input int unsigned len);
    bp_bedrock_mem_msg_s m;
    beat_exp_s b;
    int unsigned bytes;
    pending++;
    for (int unsigned off = 0; off < len; off += 8) begin
      m = '0;
      m.header.msg_type       = e_bedrock_mem_uc_rd;
      m.header.subop          = e_bedrock_load;
      m.header.size           = e_bedrock_msg_size_8;
      m.header.addr           = m_buf + AW'(off);
      m.header.payload.lce_id = lce_id_i;
      exp_cmd_q.push_back(m);
      bytes  = (len - off >= 8) ? 8 : len - off;
      b.keep = 8'hFF >> (8 - bytes);
      b.last = (off + 8 >= len);
      exp_beat_q.push_back(b);
    end
  endtask

  task automatic issue(input logic [2:0] code, input logic [AW-1:0] arg);
    eth_cmd_i = code; eth_cmd_arg_i = arg; eth_cmd_v_i = 1'b1;
    if (code == 3'b011 && pending == 0) begin
      m_buf = arg; cfg = 1'b1;
    end else if (code == 3'b100 && cfg && pending == 0 && arg[15:0] != 16'd0) begin
      expect_frame(int'(arg[15:0]));
    end
    tick();
    eth_cmd_v_i = 1'b0;
    eth_cmd_i = 3'($urandom);
  endtask

  task automatic check_ext();
    logic [1:0] e;
    e = !cfg ? 2'b00 : (pending != 0 ? 2'b01 : 2'b10);
    chk("ext_state", 64'(tx_ext_state_o), 64'(e));
  endtask

  task automatic flush_model();
    exp_cmd_q.delete(); exp_beat_q.delete(); data_q.delete();
    pending = 0; cfg = 1'b0;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; eth_cmd_v_i = 1'b0;
    #1;
    chk("rst_cmd_v", 64'(io_cmd_v_o), 64'd0);
    chk("rst_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
    chk("rst_resp_ready", 64'(io_resp_ready_o), 64'd0);
    chk("rst_tkeep", 64'({tx_axis_tkeep_o, tx_axis_tlast_o}), 64'd0);
    chk("rst_tdata", tx_axis_tdata_o, 64'd0);
    chk_msg("rst_cmd_msg", io_cmd_o, '0);
    chk("rst_ext", 64'(tx_ext_state_o), 64'd0);
    repeat (3) tick();
    flush_model();
    reset_n_i = 1'b1;
    tick();
    check_ext();
  endtask

  task automatic random_cmd();
    logic [2:0] code;
    code = 3'($urandom_range(0, 7));
    if (code == 3'b100) issue(code, {24'($urandom), 16'($urandom_range(1, 40))});
    else issue(code, {8'($urandom), $urandom});
  endtask

  task automatic wait_idle(input bit noise);
    int unsigned n = 0;
    while (pending != 0 && n < 3000) begin
      check_ext();
      if (noise && $urandom_range(0, 7) == 0) random_cmd();
      else tick();
      n++;
    end
    if (pending != 0) begin
      total++; bad++;
      $display("FAIL frame_timeout act=pending %0d exp=0", pending);
      do_reset();
    end else begin
      check_ext();
    end
  endtask

  // Memory responder: variable accept and response latency.
  initial begin
    bit cf, rf, pend;
    int unsigned dly, vcnt, target;
    bp_bedrock_mem_msg_s r;
    logic [95:0] rnd;
    pend = 0; dly = 0; vcnt = 0; target = 0;
    forever begin
      @(negedge clk);
      cf = io_cmd_v_o && io_cmd_yumi_i;
      rf = io_resp_v_i && io_resp_ready_o;
      @(posedge clk);
      #1;
      if (!reset_n_i) begin
        io_cmd_yumi_i = 1'b0; io_resp_v_i = 1'b0; pend = 0; vcnt = 0;
        continue;
      end
      if (cf) begin pend = 1; dly = $urandom_range(0, 3); end
      if (rf) io_resp_v_i = 1'b0;
      if (pend && !io_resp_v_i) begin
        if (dly == 0) begin
          r = '0;
          for (int i = 0; i < 16; i++) r.data[i*32 +: 32] = $urandom;
          rnd = {$urandom, $urandom, $urandom};
          r.header = rnd[$bits(bp_bedrock_mem_header_s)-1:0];
          io_resp_i = r;
          io_resp_v_i = 1'b1;
          data_q.push_back(r.data[63:0]);
          pend = 0;
        end else dly--;
      end
      if (io_cmd_v_o) begin
        if (vcnt == 0) target = force_yumi_delay ? 5 : $urandom_range(0, 5);
        io_cmd_yumi_i = (vcnt >= target);
        vcnt++;
      end else begin
        io_cmd_yumi_i = 1'b0; vcnt = 0;
      end
    end
  end

  // MAC side: optional forced stall, otherwise ready 3 cycles in 4.
  initial begin
    forever begin
      tick();
      if (!reset_n_i) tx_axis_tready_i = 1'b0;
      else if (tx_axis_tvalid_o && stall_left > 0) begin
        tx_axis_tready_i = 1'b0; stall_left--;
      end else tx_axis_tready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on every read handshake and every beat.
  initial begin
    bit prev_stall, prev_cmdw;
    logic [63:0] pv_data;
    logic [7:0] pv_keep;
    logic pv_last;
    logic [MSGW-1:0] pv_cmd;
    beat_exp_s e;
    logic [63:0] d;
    prev_stall = 0; prev_cmdw = 0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin prev_stall = 0; prev_cmdw = 0; continue; end
      if (prev_stall) begin
        chk("stall_tvalid", 64'(tx_axis_tvalid_o), 64'd1);
        chk("stall_tdata", tx_axis_tdata_o, pv_data);
        chk("stall_tkeep", 64'(tx_axis_tkeep_o), 64'(pv_keep));
        chk("stall_tlast", 64'(tx_axis_tlast_o), 64'(pv_last));
      end
      if (prev_cmdw) begin
        chk("cmd_hold_v", 64'(io_cmd_v_o), 64'd1);
        chk_msg("cmd_hold_msg", io_cmd_o, pv_cmd);
      end
      if (tx_axis_tvalid_o) chk("one_outstanding", 64'({io_cmd_v_o, io_resp_ready_o}), 64'd0);
      else chk("idle_axis_zero", 64'({tx_axis_tkeep_o, tx_axis_tlast_o}), 64'd0);
      chk("tuser", 64'(tx_axis_tuser_o), 64'd0);
      if (io_cmd_v_o && io_cmd_yumi_i) begin
        if (exp_cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd act=%0h exp=none", io_cmd_o);
        end else chk_msg("cmd_msg", io_cmd_o, exp_cmd_q.pop_front());
      end
      if (tx_axis_tvalid_o && tx_axis_tready_i) begin
        if (exp_beat_q.size() == 0 || data_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat act=%0h exp=none", tx_axis_tdata_o);
        end else begin
          e = exp_beat_q.pop_front();
          d = data_q.pop_front();
          chk("tdata", tx_axis_tdata_o, d);
          chk("tkeep", 64'(tx_axis_tkeep_o), 64'(e.keep));
          chk("tlast", 64'(tx_axis_tlast_o), 64'(e.last));
          if (e.last && pending > 0) pending--;
        end
      end
      prev_stall = tx_axis_tvalid_o && !tx_axis_tready_i;
      pv_data = tx_axis_tdata_o; pv_keep = tx_axis_tkeep_o; pv_last = tx_axis_tlast_o;
      prev_cmdw = io_cmd_v_o && !io_cmd_yumi_i;
      pv_cmd = io_cmd_o;
    end
  end

  initial begin
    int unsigned n;
    do_reset();

    issue(3'b100, 40'd8);
    repeat (3) begin chk("init_send_ignored", 64'(io_cmd_v_o), 64'd0); check_ext(); tick(); end

    issue(3'b011, 40'h00_8000_0000);
    check_ext();
    issue(3'b100, 40'd0);
    repeat (3) begin chk("send0_ignored", 64'(io_cmd_v_o), 64'd0); check_ext(); tick(); end

    lce_id_i = 4'h5;
    issue(3'b100, 40'd8);
    wait_idle(1'b0);

    force_yumi_delay = 1'b1;
    stall_left = 10;
    issue(3'b100, 40'd13);
    wait_idle(1'b0);
    force_yumi_delay = 1'b0;
    stall_left = 0;

    issue(3'b100, 40'd16);
    n = 0;
    while (!tx_axis_tvalid_o && n < 200) begin tick(); n++; end
    chk("reach_stream", 64'(tx_axis_tvalid_o), 64'd1);
    issue(3'b011, 40'h00_0000_1234);
    wait_idle(1'b0);
    issue(3'b100, 40'd8);
    wait_idle(1'b0);

    issue(3'b011, 40'hFF_FFFF_FFF8);
    issue(3'b100, 40'd13);
    wait_idle(1'b0);

    issue(3'b011, 40'h00_0000_0100);
    issue(3'b100, 40'd16);
    n = 0;
    while (!io_resp_ready_o && n < 200) begin tick(); n++; end
    chk("reach_wait_resp", 64'(io_resp_ready_o), 64'd1);
    do_reset();

    for (int f = 0; f < 24; f++) begin
      lce_id_i = LW'($urandom);
      if ($urandom_range(0, 3) == 0) stall_left = $urandom_range(1, 6);
      if ($urandom_range(0, 2) == 0) issue(3'b011, {8'($urandom), $urandom});
      issue(3'b100, {24'($urandom), 16'($urandom_range(1, 40))});
      wait_idle(1'b1);
    end
    repeat (4) tick();
    chk("cmd_q_drained", 64'(exp_cmd_q.size()), 64'd0);
    chk("beat_q_drained", 64'(exp_beat_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
